// File: rtl/disp_scan_ctl_pkg.sv
// Shared display definitions: d_out field positions, the blank code and a code builder.
// Used by disp_scan_ctl (optional leading-zero blanking via DISP_SCAN_LZB_EN).
package disp_scan_ctl_pkg;

   localparam int DOUT_W    = 7;
   localparam int BLANK_BIT = 6;
   localparam int DP_BIT    = 5;
   localparam int DASH_BIT  = 4;
   localparam int NIB_LSB   = 0;
   localparam int NIB_W     = 4;

   typedef logic [DOUT_W-1:0] dcode_t;

   localparam dcode_t BLANK_CODE = 7'h40;

   // Blank overrides dash, which overrides the plain nibble; dp always passes through.
   function automatic dcode_t make_code(input logic blank, input logic dp,
                                        input logic dash, input logic [NIB_W-1:0] nib);
      dcode_t c;
      c         = '0;
      c[DP_BIT] = dp;
      if (blank) begin
         c[BLANK_BIT] = 1'b1;
      end else begin
         c[NIB_LSB +: NIB_W] = nib;
         c[DASH_BIT]         = dash;
      end
      return c;
   endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// Slot prescaler: counts 0..DIV-1 while enabled; tick is high in the cycle that wraps.
module disp_tick_gen #(
   parameter int DIV = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int CW = $clog2(DIV);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      tick  = en && (cnt_q == CW'(DIV - 1));
      if (en) begin
         cnt_d = tick ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/disp_scan_ctl.sv
// Multiplexed digit scan controller with double-buffered display data, frame-aligned updates.
// Define DISP_SCAN_LZB_EN to enable leading-zero blanking.
module disp_scan_ctl
   import disp_scan_ctl_pkg::*;
#(
   parameter int NDIG = 8,
   parameter int DIV  = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              load,
   input  logic [4*NDIG-1:0] val,
   input  logic [NDIG-1:0]   dp_mask,
   input  logic [NDIG-1:0]   dash_mask,
   input  logic [NDIG-1:0]   blank_mask,
   output logic [6:0]        d_out,
   output logic [NDIG-1:0]   an_n,
   output logic              upd_pend,
   output logic              frame_done
);

   localparam int IDX_W = $clog2(NDIG);

   logic              tick;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [4*NDIG-1:0] act_val_q, act_val_d, sh_val_q, sh_val_d;
   logic [NDIG-1:0]   act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
   logic [NDIG-1:0]   act_dash_q, act_dash_d, sh_dash_q, sh_dash_d;
   logic [NDIG-1:0]   act_blank_q, act_blank_d, sh_blank_q, sh_blank_d;
   logic              pend_q, pend_d;
   logic [NDIG-1:0]   lz_vec;
   dcode_t            dout_q, dout_d;
   logic [NDIG-1:0]   an_n_q, an_n_d;

   disp_tick_gen #(.DIV(DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .tick  (tick)
   );

   always_comb begin
      idx_d       = idx_q;
      frame_done  = tick && (idx_q == IDX_W'(NDIG - 1));
      act_val_d   = act_val_q;
      act_dp_d    = act_dp_q;
      act_dash_d  = act_dash_q;
      act_blank_d = act_blank_q;
      sh_val_d    = sh_val_q;
      sh_dp_d     = sh_dp_q;
      sh_dash_d   = sh_dash_q;
      sh_blank_d  = sh_blank_q;
      pend_d      = pend_q;
      if (tick) begin
         idx_d = frame_done ? '0 : idx_q + IDX_W'(1);
      end
      // A load landing on the frame boundary bypasses the shadow copy entirely.
      if (load && frame_done) begin
         act_val_d   = val;
         act_dp_d    = dp_mask;
         act_dash_d  = dash_mask;
         act_blank_d = blank_mask;
         pend_d      = 1'b0;
      end else begin
         if (frame_done && pend_q) begin
            act_val_d   = sh_val_q;
            act_dp_d    = sh_dp_q;
            act_dash_d  = sh_dash_q;
            act_blank_d = sh_blank_q;
            pend_d      = 1'b0;
         end
         if (load) begin
            sh_val_d   = val;
            sh_dp_d    = dp_mask;
            sh_dash_d  = dash_mask;
            sh_blank_d = blank_mask;
            pend_d     = 1'b1;
         end
      end
   end

   always_comb begin
      lz_vec = '0;
`ifdef DISP_SCAN_LZB_EN
      begin
         logic run;
         run = 1'b1;
         for (int i = NDIG - 1; i >= 1; i--) begin
            run       = run && (act_val_q[4*i +: 4] == 4'h0) && !act_dash_q[i] && !act_dp_q[i];
            lz_vec[i] = run;
         end
      end
`endif
   end

   always_comb begin
      dout_d = BLANK_CODE;
      an_n_d = '1;
      if (en) begin
         dout_d = make_code(act_blank_q[idx_q] || lz_vec[idx_q], act_dp_q[idx_q],
                            act_dash_q[idx_q], act_val_q[4*idx_q +: 4]);
         an_n_d = ~(NDIG'(1) << idx_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         act_val_q   <= '0;
         act_dp_q    <= '0;
         act_dash_q  <= '0;
         act_blank_q <= '0;
         sh_val_q    <= '0;
         sh_dp_q     <= '0;
         sh_dash_q   <= '0;
         sh_blank_q  <= '0;
         pend_q      <= 1'b0;
         dout_q      <= BLANK_CODE;
         an_n_q      <= '1;
      end else begin
         idx_q       <= idx_d;
         act_val_q   <= act_val_d;
         act_dp_q    <= act_dp_d;
         act_dash_q  <= act_dash_d;
         act_blank_q <= act_blank_d;
         sh_val_q    <= sh_val_d;
         sh_dp_q     <= sh_dp_d;
         sh_dash_q   <= sh_dash_d;
         sh_blank_q  <= sh_blank_d;
         pend_q      <= pend_d;
         dout_q      <= dout_d;
         an_n_q      <= an_n_d;
      end
   end

   assign d_out    = dout_q;
   assign an_n     = an_n_q;
   assign upd_pend = pend_q;

endmodule

// File: tb/tb_disp_scan_ctl.sv
// Directed and randomized bench for disp_scan_ctl (NDIG=4, DIV=4) against a behavioural model.
module tb_disp_scan_ctl;

   localparam int NDIG = 4;
   localparam int DIV  = 4;

   logic        clk = 1'b0;
   logic        rst_n, en, load;
   logic [15:0] val;
   logic [3:0]  dp_mask, dash_mask, blank_mask;
   logic [6:0]  d_out;
   logic [3:0]  an_n;
   logic        upd_pend, frame_done;

   always #5 clk = ~clk;

   disp_scan_ctl #(.NDIG(NDIG), .DIV(DIV)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .load       (load),
      .val        (val),
      .dp_mask    (dp_mask),
      .dash_mask  (dash_mask),
      .blank_mask (blank_mask),
      .d_out      (d_out),
      .an_n       (an_n),
      .upd_pend   (upd_pend),
      .frame_done (frame_done)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Model: slot position as plain integers plus displayed/pending frame contents.
   int          m_cnt, m_idx;
   logic [15:0] a_val, s_val;
   logic [3:0]  a_dp, a_dash, a_blank, s_dp, s_dash, s_blank;
   bit          m_pend;
   logic [6:0]  m_dout;
   logic [3:0]  m_an;

   function automatic logic [6:0] exp_code(input int d);
      logic [6:0] c;
      bit         lzb;
      lzb = 1'b0;
`ifdef DISP_SCAN_LZB_EN
      if (d > 0) begin
         lzb = 1'b1;
         for (int j = d; j < NDIG; j++)
            if (a_val[4*j +: 4] != 4'h0 || a_dash[j] || a_dp[j]) lzb = 1'b0;
      end
`endif
      if (a_blank[d] || lzb)  c = {1'b1, a_dp[d], 5'b00000};
      else if (a_dash[d])     c = {1'b0, a_dp[d], 1'b1, a_val[4*d +: 4]};
      else                    c = {1'b0, a_dp[d], 1'b0, a_val[4*d +: 4]};
      return c;
   endfunction

   function automatic bit m_fd_now();
      return en && (m_cnt == DIV - 1) && (m_idx == NDIG - 1);
   endfunction

   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_idx = 0; m_pend = 1'b0;
      a_val = '0; a_dp = '0; a_dash = '0; a_blank = '0;
      s_val = '0; s_dp = '0; s_dash = '0; s_blank = '0;
      m_dout = 7'h40; m_an = 4'hF;
   endtask

   // Inputs are already applied; check, advance the model one clock, then clock the DUT.
   task automatic cyc();
      bit tick, fd;
      #1;
      check("frame_done", {6'b0, frame_done}, {6'b0, m_fd_now()});
      check("upd_pend",   {6'b0, upd_pend},   {6'b0, m_pend});
      check("d_out",      d_out,              m_dout);
      check("an_n",       {3'b0, an_n},       {3'b0, m_an});
      tick   = en && (m_cnt == DIV - 1);
      fd     = tick && (m_idx == NDIG - 1);
      m_dout = en ? exp_code(m_idx) : 7'h40;
      m_an   = en ? ~(4'b0001 << m_idx) : 4'hF;
      if (en) m_cnt = (m_cnt + 1) % DIV;
      if (tick) m_idx = (m_idx + 1) % NDIG;
      if (load && fd) begin
         a_val = val; a_dp = dp_mask; a_dash = dash_mask; a_blank = blank_mask;
         m_pend = 1'b0;
      end else begin
         if (fd && m_pend) begin
            a_val = s_val; a_dp = s_dp; a_dash = s_dash; a_blank = s_blank;
            m_pend = 1'b0;
         end
         if (load) begin
            s_val = val; s_dp = dp_mask; s_dash = dash_mask; s_blank = blank_mask;
            m_pend = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] dash,
                          input logic [3:0] blank);
      load = 1'b1; val = v; dp_mask = dp; dash_mask = dash; blank_mask = blank;
      cyc();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      check("rst d_out",      d_out,              7'h40);
      check("rst an_n",       {3'b0, an_n},       7'h0F);
      check("rst upd_pend",   {6'b0, upd_pend},   7'h00);
      check("rst frame_done", {6'b0, frame_done}, 7'h00);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_slot(input int idx, input int cnt);
      int guard;
      guard = 0;
      while (!(m_idx == idx && m_cnt == cnt) && guard < 4 * DIV * NDIG) begin
         cyc();
         guard++;
      end
      n_assert++;
      assert (m_idx == idx && m_cnt == cnt) else begin
         n_fail++;
         $error("FAIL wait_slot observed=%0d expected=%0d", m_idx, idx);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; en = 1'b0; load = 1'b0;
      val = '0; dp_mask = '0; dash_mask = '0; blank_mask = '0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();
      en = 1'b1;
      run(40);

      wait_slot(1, 2);
      do_load(16'h1234, 4'h0, 4'h0, 4'h0);
      run(36);

      wait_slot(0, 1);
      do_load(16'hAAAA, 4'h0, 4'h0, 4'h0);
      run(3);
      do_load(16'h5555, 4'h0, 4'h0, 4'h0);
      run(30);

      wait_slot(NDIG - 1, DIV - 1);
      do_load(16'h9876, 4'h0, 4'h0, 4'h0);
      run(20);

      do_load(16'h4321, 4'b0100, 4'b0011, 4'b0001);
      run(36);

      do_load(16'h0005, 4'h0, 4'h0, 4'h0);
      run(36);
      do_load(16'h0000, 4'h0, 4'h0, 4'h0);
      run(36);

      wait_slot(1, 1);
      en = 1'b0;
      run(4);
      do_load(16'hBEEF, 4'h2, 4'h0, 4'h0);
      run(5);
      en = 1'b1;
      run(36);

      wait_slot(2, 0);
      do_load(16'hC0DE, 4'h1, 4'h0, 4'h0);
      run(2);
      do_reset();
      run(36);

      for (int i = 0; i < 400; i++) begin
         en = ($urandom % 8) != 0;
         if (($urandom % 10) == 0) begin
            load = 1'b1;
            val = 16'($urandom);
            dp_mask = 4'($urandom);
            dash_mask = 4'($urandom) & 4'($urandom);
            blank_mask = 4'($urandom) & 4'($urandom) & 4'($urandom);
         end
         if (i == 200) do_reset();
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/disp_scan_ctl.md
DISP_SCAN_CTL -- requirements
Module: disp_scan_ctl

Interface
REQ-001 SHALL have parameter NDIG, default 8: number of multiplexed digits, range 2..8.
REQ-002 SHALL have parameter DIV, default 100000: clock cycles per digit slot, minimum 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  scan enable.
REQ-006 SHALL have port load  input  1  one-cycle request to capture val and the three masks.
REQ-007 SHALL have port val  input  4*NDIG  hex nibbles; nibble i drives digit i, digit 0 least significant.
REQ-008 SHALL have ports dp_mask, dash_mask, blank_mask  input  NDIG each  per-digit decimal point, dash and blank requests.
REQ-009 SHALL have port d_out  output  7  decoder code: bit6 blank, bit5 dp, bit4 dash, bits3:0 nibble.
REQ-010 SHALL have port an_n  output  NDIG  active-low digit select, at most one bit low.
REQ-011 SHALL have port upd_pend  output  1  high while a captured load is waiting for a frame boundary.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at the end of the last digit slot.

Function
REQ-013 SHALL run a prescaler counting 0..DIV-1 while en=1; its wrap from DIV-1 to 0 is a slot tick.
REQ-014 SHALL advance digit index idx on each slot tick, modulo NDIG, wrapping from NDIG-1 to 0.
REQ-015 SHALL assert frame_done in the cycle in which the tick occurs with idx=NDIG-1.
REQ-016 SHALL register d_out and an_n: both reflect idx and the active registers one cycle after the change, with no combinational path from inputs.
REQ-017 SHALL hold an_n[idx]=0 and all other an_n bits at 1 while en=1.
REQ-018 SHALL, when load=1, capture val and the masks into shadow registers and set upd_pend.
REQ-019 SHALL overwrite the shadow registers with the latest data if load recurs while upd_pend=1.
REQ-020 SHALL, on a frame_done cycle with upd_pend=1, copy shadow to active registers and clear upd_pend, so a frame never mixes old and new data.
REQ-021 SHALL, when load and frame_done coincide, apply the new load data directly to the active registers and leave upd_pend=0.
REQ-022 SHALL compose d_out for digit i with priority blank_mask[i] > dash_mask[i] > nibble; dp is taken from dp_mask[i] in every case.
REQ-023 SHALL, when en=0, freeze the prescaler and idx, drive an_n all ones and d_out=7'h40, and continue to accept loads.
REQ-024 SHALL restart scanning from the frozen idx and prescaler values when en returns to 1.

Reset
REQ-025 SHALL, while rst_n=0, clear the prescaler, idx, active and shadow registers, upd_pend and frame_done.
REQ-026 SHALL hold d_out=7'h40 and an_n all ones while rst_n=0.
REQ-027 SHALL, when reset is asserted mid-frame or with a load pending, discard the pending data; the first slot after release is digit 0.

Configuration
REQ-028 SHALL provide leading-zero blanking when macro DISP_SCAN_LZB_EN is defined.
REQ-029 With DISP_SCAN_LZB_EN defined, digit i>0 SHALL be blanked when all active nibbles i..NDIG-1 are zero and no dash or dp bit is set on digits i..NDIG-1; digit 0 SHALL never be blanked by this rule.
REQ-030 Without DISP_SCAN_LZB_EN, all digits SHALL be displayed as REQ-022 specifies.

Structure
REQ-031 SHALL place the d_out field bit-position constants (blank, dp, dash, nibble) and the 7'h40 blank code in the shared display package.
REQ-032 SHALL implement the prescaler as sub-module disp_tick_gen (parameter DIV; ports clk, rst_n, en, tick).
REQ-033 SHALL feed d_out unmodified to the downstream active-low seven-segment decoder.

Verification (NDIG=4, DIV=4)
REQ-034 Reset release with en=1 and no load -> an_n sequence 1110,1101,1011,0111 with 4 cycles per slot; d_out=7'h00; frame_done pulses every 16 cycles.
REQ-035 load with val=16'h1234 mid-frame -> upd_pend=1 until the next frame_done; the following frame shows nibbles 4,3,2,1 and no frame mixes old and new data.
REQ-036 Two loads (16'hAAAA, then 16'h5555) within one frame -> only 5555 is displayed; load coinciding with frame_done -> applied immediately and upd_pend stays 0.
REQ-037 blank_mask=4'b0001, dash_mask=4'b0011, dp_mask=4'b0100 -> digit0 d_out bit6=1, digit1=7'h10|nibble, digit2 bit5 set.
REQ-038 With DISP_SCAN_LZB_EN defined, val=16'h0005 -> digits 3..1 d_out=7'h40 and digit 0 d_out=7'h05; val=16'h0000 -> digit 0 d_out=7'h00.
REQ-039 en dropped for 10 cycles mid-slot, then rst_n pulsed low mid-frame with a load pending -> an_n=1111 and d_out=7'h40 while en=0, scan resumes from the frozen idx, and reset clears upd_pend with the next frame starting at digit 0.
